operand_issue: RTL and testbench
================================

OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 The block SHALL have no parameters; the data width is 4 bits and the register file holds 4 entries.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 instr  input  7  [6]=op (1=SRL, 0=MOV), [5:4]=rd, [3:2]=rs1, [1:0]=rs2.
REQ-007 alu_en  output  1  enable to the downstream shift-right unit.
REQ-008 alu_rd1  output  4  shift operand (value to shift), registered.
REQ-009 alu_rd2  output  4  shift amount operand, registered.
REQ-010 alu_result  input  4  combinational result returned by the shift-right unit.
REQ-011 wr_en, wr_addr[1:0], wr_data[3:0]  input  external register-load port.
REQ-012 rf_raddr  input  2  debug read address.
REQ-013 rf_rdata  output  4  combinational register contents at rf_raddr.
REQ-014 done  output  1  one-cycle pulse on writeback.

Function
REQ-015 The FSM SHALL have four states, IDLE, READ, EXEC and WB, and SHALL advance IDLE->READ->EXEC->WB->IDLE.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 An instruction SHALL be accepted on a rising edge where instr_valid=1 and instr_ready=1, and instr SHALL be latched on that edge.
REQ-018 The transition from READ to EXEC SHALL latch alu_rd1<=RF[rs1] and alu_rd2<=RF[rs2].
REQ-019 alu_en SHALL be 1 only in EXEC and only when op=1; it SHALL be 0 in all other cases.
REQ-020 The EXEC->WB edge SHALL capture the writeback value: alu_result if op=1, alu_rd1 if op=0.
REQ-021 In WB, the captured writeback value SHALL be written to RF[rd] on the WB->IDLE edge.
REQ-022 done SHALL be 1 during WB.
REQ-023 Latency: for an instruction accepted at edge N, done SHALL be high in the cycle after edge N+2, and RF SHALL be updated at edge N+3.
REQ-024 The minimum issue interval SHALL be 4 cycles, with no back-to-back acceptance.
REQ-025 An external write (wr_en=1) SHALL update RF[wr_addr] on the clock edge in any state.
REQ-026 When the WB write and an external write target the same address on the same edge, the WB write SHALL take effect and the external write SHALL be dropped.
REQ-027 When the WB write and an external write target different addresses on the same edge, both writes SHALL take effect.
REQ-028 rd may equal rs1 or rs2; operands SHALL be the values latched in READ, and the write SHALL occur only in WB.
REQ-029 No arithmetic width growth SHALL occur; all data paths are 4 bits.
REQ-030 instr_valid while instr_ready=0 SHALL be ignored; the instruction source must hold instr until it is accepted.

Reset
REQ-031 Asserting rst SHALL asynchronously force the state to IDLE and RF[0..3]=0.
REQ-032 Asserting rst SHALL asynchronously force alu_rd1=0, alu_rd2=0, alu_en=0, done=0, the latched instr to 0, and instr_ready=1 after reset.
REQ-033 Reset during READ, EXEC or WB SHALL abort the instruction, and no RF write SHALL occur.

Configuration
REQ-034 The macro OPERAND_ISSUE_BYPASS_EN SHALL control external-write bypass.
REQ-035 When OPERAND_ISSUE_BYPASS_EN is defined: if wr_en=1 on the READ->EXEC latch edge and wr_addr equals rs1 (or rs2), alu_rd1 (or alu_rd2) SHALL latch wr_data instead of RF contents.
REQ-036 When OPERAND_ISSUE_BYPASS_EN is not defined, alu_rd1 and alu_rd2 SHALL latch pre-edge RF contents, and the external write SHALL land only in RF.

Verification
REQ-037 Reset, then rf_raddr=0..3 -> rf_rdata=0 for each address, and instr_ready=1.
REQ-038 Load R1=4'b1100 and R2=2, issue SRL rd=3, rs1=1, rs2=2 -> alu_en high for 1 cycle with alu_rd1=12 and alu_rd2=2, shifter returns 3, done pulse, R3=3 exactly 3 edges after acceptance.
REQ-039 Issue MOV rd=0, rs1=1 with R1=9 -> alu_en stays 0 and R0=9 after done.
REQ-040 During WB of an instruction with rd=2, drive wr_en=1, wr_addr=2, wr_data=7 -> R2 holds the WB value; repeating with wr_addr=1 writes both registers.
REQ-041 Assert rst in EXEC -> no done pulse, all registers 0, and the next instruction is accepted normally.
REQ-042 With OPERAND_ISSUE_BYPASS_EN defined, R1=1 and wr_en to R1 with value 8 on the READ edge -> alu_rd1=8; without the macro -> alu_rd1=1.

Source files
------------

// File: rtl/operand_issue.sv
// operand_issue: 4x4-bit register file feeding an external shift-right unit through an IDLE/READ/EXEC/WB FSM;
// instr_ready only in IDLE, RF write 3 edges after accept. `OPERAND_ISSUE_BYPASS_EN forwards same-edge external writes into operands.
module operand_issue (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [6:0] instr,
   output logic       alu_en,
   output logic [3:0] alu_rd1,
   output logic [3:0] alu_rd2,
   input  logic [3:0] alu_result,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic [1:0] rf_raddr,
   output logic [3:0] rf_rdata,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t     state_q;
   logic [6:0] instr_q;
   logic [3:0] rf_q [4];
   logic [3:0] wb_q;
   logic [3:0] rd1_q, rd2_q;
   logic       ready_q, alu_en_q, done_q;
   logic [3:0] opnd1_d, opnd2_d;
   logic       op;
   logic [1:0] rd, rs1, rs2;
   logic       wb_hits_ext;

   assign op  = instr_q[6];
   assign rd  = instr_q[5:4];
   assign rs1 = instr_q[3:2];
   assign rs2 = instr_q[1:0];

   // The writeback owns the register when both ports target it on the same edge.
   assign wb_hits_ext = (state_q == WB) && (wr_addr == rd);

   always_comb begin
      opnd1_d = rf_q[rs1];
      opnd2_d = rf_q[rs2];
`ifdef OPERAND_ISSUE_BYPASS_EN
      if (wr_en && (wr_addr == rs1)) opnd1_d = wr_data;
      if (wr_en && (wr_addr == rs2)) opnd2_d = wr_data;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         wb_q     <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         ready_q  <= 1'b1;
         alu_en_q <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else begin
         if (wr_en && !wb_hits_ext) rf_q[wr_addr] <= wr_data;
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr;
                  ready_q <= 1'b0;
                  state_q <= READ;
               end
            end
            READ: begin
               rd1_q    <= opnd1_d;
               rd2_q    <= opnd2_d;
               alu_en_q <= op;
               state_q  <= EXEC;
            end
            EXEC: begin
               wb_q     <= op ? alu_result : rd1_q;
               alu_en_q <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= WB;
            end
            WB: begin
               rf_q[rd] <= wb_q;
               done_q   <= 1'b0;
               ready_q  <= 1'b1;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign alu_en      = alu_en_q;
   assign alu_rd1     = rd1_q;
   assign alu_rd2     = rd2_q;
   assign done        = done_q;
   assign rf_rdata    = rf_q[rf_raddr];
endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: transaction-level reference model + scoreboard, directed cases then random traffic.
module tb_operand_issue;
   logic       clk, rst, instr_valid, instr_ready, alu_en, wr_en, done;
   logic [6:0] instr;
   logic [3:0] alu_rd1, alu_rd2, alu_result, wr_data, rf_rdata;
   logic [1:0] wr_addr, rf_raddr, main_addr, mon_addr;
   logic       dir_sel;
   int         checks = 0, failures = 0;

`ifdef OPERAND_ISSUE_BYPASS_EN
   localparam logic [3:0] BYP_RD1 = 4'd8;
`else
   localparam logic [3:0] BYP_RD1 = 4'd1;
`endif

   // Downstream shift-right unit.
   assign alu_result = alu_rd1 >> alu_rd2;
   assign rf_raddr   = dir_sel ? main_addr : mon_addr;

   operand_issue dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_en(alu_en), .alu_rd1(alu_rd1), .alu_rd2(alu_rd2),
      .alu_result(alu_result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .done(done)
   );

   initial begin
      clk = 0;
      forever #10 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic       op;
      logic [1:0] rd;
      logic [3:0] a, b, wb;
      int         done_cyc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       pend;
   logic [3:0] rf_m [4];
   logic [3:0] nrf  [4];
   int         age = -1;
   int         cyc = 0;
   int         acc_cyc = 0;
   logic [6:0] cur;

   function automatic logic [3:0] opnd(input logic [1:0] r);
      logic [3:0] v;
      v = rf_m[r];
`ifdef OPERAND_ISSUE_BYPASS_EN
      if (wr_en && wr_addr == r) v = wr_data;
`endif
      return v;
   endfunction

   initial begin
      for (int k = 0; k < 4; k++) rf_m[k] = 4'd0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            for (int k = 0; k < 4; k++) rf_m[k] = 4'd0;
            age = -1;
            exp_q.delete();
         end else begin
            nrf = rf_m;
            if (wr_en) nrf[wr_addr] = wr_data;
            if (age == 0) begin
               pend.op       = cur[6];
               pend.rd       = cur[5:4];
               pend.a        = opnd(cur[3:2]);
               pend.b        = opnd(cur[1:0]);
               pend.wb       = cur[6] ? (pend.a >> pend.b) : pend.a;
               pend.done_cyc = acc_cyc + 2;
               exp_q.push_back(pend);
            end
            if (age == 2) nrf[pend.rd] = pend.wb;
            rf_m = nrf;
            if (age >= 0) age = (age == 2) ? -1 : age + 1;
            else if (instr_valid) begin
               cur     = instr;
               age     = 0;
               acc_cyc = cyc;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int         en_seen = 0;
   int         done_cnt = 0;
   logic       mon_rf_pending = 0;
   logic [3:0] mon_rf_exp;
   exp_t       e;

   initial begin
      mon_addr = 2'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            en_seen = 0;
            mon_rf_pending = 0;
         end else begin
            if (mon_rf_pending) begin
               chk("wb_rf_value", int'(rf_rdata), int'(mon_rf_exp));
               mon_rf_pending = 0;
            end
            chk("instr_ready", int'(instr_ready), int'(age == -1));
            if (alu_en) begin
               en_seen++;
               if (exp_q.size() == 0) chk("alu_en_unexpected", int'(alu_en), 0);
               else begin
                  chk("alu_en_cycle", cyc, exp_q[0].done_cyc - 1);
                  chk("alu_en_op", int'(alu_en), int'(exp_q[0].op));
                  chk("alu_rd1_exec", int'(alu_rd1), int'(exp_q[0].a));
                  chk("alu_rd2_exec", int'(alu_rd2), int'(exp_q[0].b));
               end
            end
            if (done) begin
               done_cnt++;
               if (exp_q.size() == 0) chk("done_unexpected", int'(done), 0);
               else begin
                  e = exp_q.pop_front();
                  chk("done_cycle", cyc, e.done_cyc);
                  chk("alu_rd1_wb", int'(alu_rd1), int'(e.a));
                  chk("alu_rd2_wb", int'(alu_rd2), int'(e.b));
                  chk("alu_en_pulses", en_seen, int'(e.op));
                  mon_addr = e.rd;
                  mon_rf_exp = e.wb;
                  mon_rf_pending = 1;
               end
               en_seen = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [3:0] exp);
      dir_sel = 1;
      main_addr = a;
      #1;
      chk(name, int'(rf_rdata), int'(exp));
      dir_sel = 0;
   endtask

   task automatic check_rf();
      for (int a = 0; a < 4; a++) rd_chk("rf_vs_model", 2'(a), rf_m[a]);
   endtask

   task automatic load(input logic [1:0] a, input logic [3:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 0;
   endtask

   task automatic issue(input logic [6:0] ins);
      int n = 0;
      while (!instr_ready && n < 20) begin tick(); n++; end
      chk("issue_ready_wait", int'(instr_ready), 1);
      instr = ins; instr_valid = 1;
      tick();
      instr_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((age != -1 || !instr_ready) && n < 20) begin tick(); n++; end
      chk("idle_timeout", int'(instr_ready && age == -1), 1);
   endtask

   logic acc;
   int   dsave;

   initial begin
      rst = 1; instr_valid = 0; instr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
      dir_sel = 0; main_addr = '0;
      tick(); tick();
      rst = 0;
      tick();

      // Reset state
      for (int a = 0; a < 4; a++) rd_chk("reset_rf", 2'(a), 4'd0);
      chk("reset_ready", int'(instr_ready), 1);
      chk("reset_alu_en", int'(alu_en), 0);
      chk("reset_done", int'(done), 0);

      // SRL R3 = R1 >> R2 with exact timing
      load(2'd1, 4'b1100);
      load(2'd2, 4'd2);
      issue({1'b1, 2'd3, 2'd1, 2'd2});
      chk("srl_read_ready", int'(instr_ready), 0);
      tick();
      chk("srl_exec_en", int'(alu_en), 1);
      chk("srl_exec_rd1", int'(alu_rd1), 12);
      chk("srl_exec_rd2", int'(alu_rd2), 2);
      chk("srl_exec_done", int'(done), 0);
      tick();
      chk("srl_wb_en", int'(alu_en), 0);
      chk("srl_wb_done", int'(done), 1);
      rd_chk("srl_r3_before_wb_edge", 2'd3, 4'd0);
      tick();
      chk("srl_idle_done", int'(done), 0);
      rd_chk("srl_r3", 2'd3, 4'd3);

      // MOV R0 = R1
      load(2'd1, 4'd9);
      issue({1'b0, 2'd0, 2'd1, 2'd3});
      tick();
      chk("mov_exec_en", int'(alu_en), 0);
      wait_idle();
      rd_chk("mov_r0", 2'd0, 4'd9);

      // WB and external write collide on R2: WB wins
      issue({1'b0, 2'd2, 2'd1, 2'd0});
      tick(); tick();
      wr_en = 1; wr_addr = 2'd2; wr_data = 4'd7;
      tick();
      wr_en = 0;
      rd_chk("collide_r2", 2'd2, 4'd9);

      // WB to R2, external write to R1: both land
      issue({1'b0, 2'd2, 2'd1, 2'd0});
      tick(); tick();
      wr_en = 1; wr_addr = 2'd1; wr_data = 4'd7;
      tick();
      wr_en = 0;
      rd_chk("dual_r2", 2'd2, 4'd9);
      rd_chk("dual_r1", 2'd1, 4'd7);
      check_rf();

      // Reset in EXEC aborts the instruction
      issue({1'b1, 2'd0, 2'd1, 2'd3});
      tick();
      dsave = done_cnt;
      rst = 1;
      tick();
      rst = 0;
      tick(); tick(); tick();
      chk("abort_no_done", done_cnt, dsave);
      for (int a = 0; a < 4; a++) rd_chk("abort_rf_zero", 2'(a), 4'd0);
      chk("abort_ready", int'(instr_ready), 1);

      // Operand latch versus same-edge external write (next instruction after reset)
      load(2'd1, 4'd1);
      issue({1'b1, 2'd3, 2'd1, 2'd0});
      wr_en = 1; wr_addr = 2'd1; wr_data = 4'd8;
      tick();
      wr_en = 0;
      chk("bypass_rd1", int'(alu_rd1), int'(BYP_RD1));
      wait_idle();
      rd_chk("bypass_r1", 2'd1, 4'd8);
      check_rf();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         acc = instr_valid && instr_ready;
         tick();
         if (acc || !instr_valid) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr = 7'($urandom);
         end
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 2'($urandom);
         wr_data = 4'($urandom);
      end
      instr_valid = 0;
      wr_en = 0;
      tick();
      wait_idle();
      tick();
      check_rf();
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
